surf_autostart_sequencer: RTL and testbench

- Wishbone-clock-domain controller that sequences link bring-up for all 7 SURFs.
- Consumes the per-SURF train-in request, train-out ready and live flags (already synchronised to wb_clk_i).
- Drives per-SURF CIN training mode and the train_complete handshake back to the live detector.
- Shares the single input-alignment engine (eye scan / IDELAY tuner) between SURFs with a round-robin arbiter, with retry, timeout and failure reporting.

---
 rtl/surf_autostart_sequencer.sv | 171 +++++++++++++++++
 tb/tb_surf_autostart_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/surf_autostart_sequencer.sv
// Link bring-up sequencer for the SURFs: per-SURF training FSMs sharing one input-alignment
// engine through a round-robin arbiter, with retry, timeout and failure reporting.
module surf_autostart_sequencer #(
  parameter int unsigned NSURF        = 7,
  parameter int unsigned TIMEOUT_BITS = 24,
  parameter int unsigned MAX_RETRIES  = 3
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n_i,
  input  logic [NSURF-1:0] enable_i,
  input  logic [NSURF-1:0] trainin_req_i,
  input  logic [NSURF-1:0] trainout_rdy_i,
  input  logic [NSURF-1:0] surf_live_i,
  output logic [NSURF-1:0] cin_train_o,
  output logic [NSURF-1:0] train_complete_o,
  output logic [NSURF-1:0] fail_o,
  output logic             align_start_o,
  output logic [2:0]       align_surf_o,
  input  logic             align_done_i,
  input  logic             align_err_i,
  output logic             busy_o
);

  typedef enum logic [2:0] {
    StIdle, StCinTrain, StWaitGnt, StAlign, StDone, StLive, StFail
  } state_e;

  // Counter value on the cycle whose increment would set the top bit.
  localparam logic [TIMEOUT_BITS-1:0] TimeoutLast = {1'b0, {(TIMEOUT_BITS-1){1'b1}}};

  state_e                  state_q [NSURF];
  state_e                  state_d [NSURF];
  logic [2:0]              retry_q [NSURF];
  logic [2:0]              retry_d [NSURF];
  logic [TIMEOUT_BITS-1:0] tmo_cnt_q [NSURF];

  logic [NSURF-1:0] cand;
  logic             grant_vld;
  logic [2:0]       grant_idx;
  logic [2:0]       ptr_q;
  logic             done_hit;
  logic             busy_d;

  always_comb begin
    int         j;
    logic [2:0] idx;
    j         = 0;
    idx       = '0;
    cand      = '0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < int'(NSURF); i++) begin
      cand[i] = (state_q[i] == StWaitGnt) && enable_i[i] && trainin_req_i[i];
    end
    if (!busy_o) begin
      for (int k = 1; k <= int'(NSURF); k++) begin
        j = int'(ptr_q) + k;
        if (j >= int'(NSURF)) j = j - int'(NSURF);
        idx = 3'(j);
        if (!grant_vld && cand[idx]) begin
          grant_vld = 1'b1;
          grant_idx = idx;
        end
      end
    end
  end

  assign done_hit = busy_o && align_done_i;

  always_comb begin
    busy_d = busy_o;
    if (grant_vld) busy_d = 1'b1;
    else if (done_hit) busy_d = 1'b0;
  end

  always_comb begin
    logic timeout;
    logic [2:0] retry_inc;
    timeout   = 1'b0;
    retry_inc = '0;
    for (int i = 0; i < int'(NSURF); i++) begin
      state_d[i] = state_q[i];
      retry_d[i] = retry_q[i];
      timeout    = (tmo_cnt_q[i] == TimeoutLast);
      retry_inc  = retry_q[i] + 3'd1;
      if (!enable_i[i]) begin
        state_d[i] = StIdle;
        if (state_q[i] == StFail) retry_d[i] = '0;
      end else begin
        unique case (state_q[i])
          StIdle:     if (trainin_req_i[i]) state_d[i] = StCinTrain;
          StCinTrain: begin
            if (!trainin_req_i[i])     state_d[i] = StIdle;
            else if (timeout)          state_d[i] = StFail;
            else if (trainout_rdy_i[i]) state_d[i] = StWaitGnt;
          end
          StWaitGnt: begin
            if (!trainin_req_i[i]) state_d[i] = StIdle;
            else if (grant_vld && grant_idx == 3'(i)) state_d[i] = StAlign;
          end
          StAlign: begin
            // A request drop abandons the attempt; the engine's eventual done is ignored.
            if (!trainin_req_i[i]) begin
              state_d[i] = StIdle;
            end else if (done_hit && align_surf_o == 3'(i)) begin
              if (align_err_i) begin
                retry_d[i] = retry_inc;
                state_d[i] = (retry_inc == 3'(MAX_RETRIES)) ? StFail : StWaitGnt;
              end else begin
                state_d[i] = StDone;
              end
            end
          end
          StDone: begin
            if (!trainin_req_i[i])   state_d[i] = StIdle;
            else if (timeout)        state_d[i] = StFail;
            else if (surf_live_i[i]) state_d[i] = StLive;
          end
          StLive: begin
            if (!surf_live_i[i]) begin
              state_d[i] = StIdle;
              retry_d[i] = '0;
            end
          end
          StFail:  state_d[i] = StFail;
          default: state_d[i] = StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      for (int i = 0; i < int'(NSURF); i++) begin
        state_q[i]   <= StIdle;
        retry_q[i]   <= '0;
        tmo_cnt_q[i] <= '0;
      end
      cin_train_o      <= '0;
      train_complete_o <= '0;
      fail_o           <= '0;
      align_start_o    <= 1'b0;
      align_surf_o     <= '0;
      busy_o           <= 1'b0;
      ptr_q            <= 3'(NSURF - 1);
    end else begin
      for (int i = 0; i < int'(NSURF); i++) begin
        state_q[i] <= state_d[i];
        retry_q[i] <= retry_d[i];
        if (state_d[i] != state_q[i]) begin
          tmo_cnt_q[i] <= '0;
        end else if (state_q[i] == StCinTrain || state_q[i] == StDone) begin
          tmo_cnt_q[i] <= tmo_cnt_q[i] + TIMEOUT_BITS'(1);
        end else begin
          tmo_cnt_q[i] <= '0;
        end
        cin_train_o[i] <= (state_d[i] == StCinTrain) || (state_d[i] == StWaitGnt) ||
                          (state_d[i] == StAlign);
        train_complete_o[i] <= (state_d[i] == StDone) || (state_d[i] == StLive);
        fail_o[i]           <= (state_d[i] == StFail);
      end
      align_start_o <= grant_vld;
      busy_o        <= busy_d;
      if (grant_vld) begin
        align_surf_o <= grant_idx;
        ptr_q        <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_surf_autostart_sequencer.sv
// Directed bench for surf_autostart_sequencer: bring-up, arbitration order, retries,
// request loss mid-alignment, timeout, live drop and reset mid-alignment.
module tb_surf_autostart_sequencer;

  logic       clk;
  logic       rst_n;
  logic [6:0] enable;
  logic [6:0] req;
  logic [6:0] rdy;
  logic [6:0] live;
  logic [6:0] cin_train;
  logic [6:0] train_complete;
  logic [6:0] fail;
  logic       align_start;
  logic [2:0] align_surf;
  logic       align_done;
  logic       align_err;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  surf_autostart_sequencer #(
    .NSURF       (7),
    .TIMEOUT_BITS(8),
    .MAX_RETRIES (3)
  ) dut (
    .wb_clk_i        (clk),
    .wb_rst_n_i      (rst_n),
    .enable_i        (enable),
    .trainin_req_i   (req),
    .trainout_rdy_i  (rdy),
    .surf_live_i     (live),
    .cin_train_o     (cin_train),
    .train_complete_o(train_complete),
    .fail_o          (fail),
    .align_start_o   (align_start),
    .align_surf_o    (align_surf),
    .align_done_i    (align_done),
    .align_err_i     (align_err),
    .busy_o          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    enable     = 7'h7f;
    req        = '0;
    rdy        = '0;
    live       = '0;
    align_done = 1'b0;
    align_err  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic pulse_done(input logic err);
    align_done = 1'b1;
    align_err  = err;
    tick();
    align_done = 1'b0;
    align_err  = 1'b0;
  endtask

  // SURF1 already has align_start showing; three errored attempts must end in FAIL.
  task automatic surf1_err_run(input string tag);
    for (int a = 0; a < 3; a++) begin
      pulse_done(1'b1);
      if (a < 2) begin
        check({tag, "_retry_fail"}, 32'(fail), 32'h00);
        check({tag, "_retry_cin"}, 32'(cin_train), 32'h02);
        tick();
        check({tag, "_retry_start"}, 32'(align_start), 32'h1);
        check({tag, "_retry_surf"}, 32'(align_surf), 32'h1);
      end
    end
    check({tag, "_fail"}, 32'(fail), 32'h02);
    check({tag, "_fail_cin"}, 32'(cin_train), 32'h00);
  endtask

  initial begin
    // Reset state and single-SURF bring-up on SURF2
    do_reset();
    check("rst_cin", 32'(cin_train), 32'h0);
    check("rst_tc", 32'(train_complete), 32'h0);
    check("rst_fail", 32'(fail), 32'h0);
    check("rst_start", 32'(align_start), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_surf", 32'(align_surf), 32'h0);
    req[2] = 1'b1;
    tick();
    check("s2_cin", 32'(cin_train), 32'h04);
    rdy[2] = 1'b1;
    tick();
    check("s2_start_early", 32'(align_start), 32'h0);
    tick();
    check("s2_start", 32'(align_start), 32'h1);
    check("s2_surf", 32'(align_surf), 32'h2);
    check("s2_busy", 32'(busy), 32'h1);
    tick();
    check("s2_start_pulse", 32'(align_start), 32'h0);
    pulse_done(1'b0);
    check("s2_tc", 32'(train_complete), 32'h04);
    check("s2_cin_off", 32'(cin_train), 32'h00);
    check("s2_busy_off", 32'(busy), 32'h0);
    live[2] = 1'b1;
    tick();
    check("s2_live_tc", 32'(train_complete), 32'h04);

    // Round robin: pointer left at 3, then SURFs 0,3,5 ready together
    do_reset();
    req[3] = 1'b1;
    tick();
    rdy[3] = 1'b1;
    tick();
    tick();
    check("rr_pre_surf", 32'(align_surf), 32'h3);
    pulse_done(1'b0);
    req[3] = 1'b0;
    rdy    = '0;
    tick();
    check("rr_pre_idle", 32'(train_complete), 32'h0);
    req = 7'b0101001;
    tick();
    rdy = 7'b0101001;
    tick();
    tick();
    check("rr_first_start", 32'(align_start), 32'h1);
    check("rr_first_surf", 32'(align_surf), 32'h5);
    tick();
    pulse_done(1'b0);
    check("rr_clear1_busy", 32'(busy), 32'h0);
    check("rr_clear1_start", 32'(align_start), 32'h0);
    tick();
    check("rr_second_start", 32'(align_start), 32'h1);
    check("rr_second_surf", 32'(align_surf), 32'h0);
    tick();
    pulse_done(1'b0);
    check("rr_clear2_start", 32'(align_start), 32'h0);
    tick();
    check("rr_third_start", 32'(align_start), 32'h1);
    check("rr_third_surf", 32'(align_surf), 32'h3);
    pulse_done(1'b0);
    check("rr_all_tc", 32'(train_complete), 32'h29);

    // SURF1 exhausts retries, then a re-enable restarts with a cleared retry count
    do_reset();
    req[1] = 1'b1;
    tick();
    rdy[1] = 1'b1;
    tick();
    tick();
    check("s1_start", 32'(align_surf), 32'h1);
    surf1_err_run("s1a");
    tick();
    tick();
    check("s1_sticky", 32'(fail), 32'h02);
    enable[1] = 1'b0;
    tick();
    check("s1_dis_fail", 32'(fail), 32'h00);
    enable[1] = 1'b1;
    tick();
    check("s1_reen_cin", 32'(cin_train), 32'h02);
    tick();
    tick();
    check("s1b_start", 32'(align_start), 32'h1);
    surf1_err_run("s1b");

    // SURF4 drops its request mid-alignment while SURF2 waits
    do_reset();
    req = 7'b0010100;
    tick();
    rdy[4] = 1'b1;
    tick();
    rdy[2] = 1'b1;
    tick();
    check("s4_surf", 32'(align_surf), 32'h4);
    tick();
    req[4] = 1'b0;
    tick();
    check("s4_cin_drop", 32'(cin_train), 32'h04);
    check("s4_busy_hold", 32'(busy), 32'h1);
    tick();
    tick();
    check("s4_busy_still", 32'(busy), 32'h1);
    check("s4_no_start", 32'(align_start), 32'h0);
    pulse_done(1'b0);
    check("s4_late_busy", 32'(busy), 32'h0);
    check("s4_late_tc", 32'(train_complete), 32'h00);
    tick();
    check("s4_next_start", 32'(align_start), 32'h1);
    check("s4_next_surf", 32'(align_surf), 32'h2);
    check("s4_idle_cin", 32'(cin_train), 32'h04);

    // SURF6 times out in DONE, then a separate run drops live from LIVE
    do_reset();
    req[6] = 1'b1;
    tick();
    rdy[6] = 1'b1;
    tick();
    tick();
    pulse_done(1'b0);
    check("s6_tc", 32'(train_complete), 32'h40);
    repeat (127) tick();
    check("s6_pre_tmo_fail", 32'(fail), 32'h00);
    check("s6_pre_tmo_tc", 32'(train_complete), 32'h40);
    tick();
    check("s6_tmo_fail", 32'(fail), 32'h40);
    check("s6_tmo_tc", 32'(train_complete), 32'h00);
    do_reset();
    req[6] = 1'b1;
    tick();
    rdy[6] = 1'b1;
    tick();
    tick();
    pulse_done(1'b0);
    live[6] = 1'b1;
    tick();
    tick();
    check("s6_live_tc", 32'(train_complete), 32'h40);
    live[6] = 1'b0;
    tick();
    check("s6_live_drop", 32'(train_complete), 32'h00);

    // Reset while SURF3 is aligning; the pointer must return to 6
    do_reset();
    req[3] = 1'b1;
    tick();
    rdy[3] = 1'b1;
    tick();
    tick();
    check("mr_pre_surf", 32'(align_surf), 32'h3);
    tick();
    rst_n = 1'b0;
    tick();
    check("mr_cin", 32'(cin_train), 32'h0);
    check("mr_busy", 32'(busy), 32'h0);
    check("mr_surf", 32'(align_surf), 32'h0);
    check("mr_start", 32'(align_start), 32'h0);
    check("mr_tc_fail", 32'({train_complete, fail}), 32'h0);
    req   = 7'b1000001;
    rdy   = 7'b1000001;
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    check("mr_ptr_start", 32'(align_start), 32'h1);
    check("mr_ptr_surf", 32'(align_surf), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
